// File: rtl/split_pair_using_double_buffers.sv
// Splits each upstream word {a, b} into two independently drained channels.
// Latency: 1 cycle from upstream acceptance to a_valid/b_valid.
// Backpressure: up_ready drops while either two-entry buffer is full (registered only).

// Two-entry FIFO: count, write pointer and read pointer; storage is not reset.
module split_pair_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);

  logic [1:0]   cnt_q, cnt_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         push, pop;

  assign full   = (cnt_q == 2'd2);
  assign rd_vld = (cnt_q != 2'd0);
  assign rd_dat = mem_q[rd_ptr_q];

  // Next-state for count, pointers and storage; pointers are 1 bit so they wrap 1 -> 0.
  always_comb begin
    push     = wr_vld & (cnt_q != 2'd2);
    pop      = rd_rdy & (cnt_q != 2'd0);
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Control state clears asynchronously so buffered words are discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage needs no reset: it is only observed when the count says it is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

module split_pair_using_double_buffers #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [2*width-1:0] up_data,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [width-1:0]   a_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [width-1:0]   b_data
);

  logic full_a, full_b;
  logic up_xfer;

  // Both halves are written together, so accept only when neither side is full.
  always_comb begin
    up_ready = ~full_a & ~full_b;
    up_xfer  = up_valid & up_ready;
  end

  split_pair_fifo2 #(.W(width)) u_buf_a (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (up_xfer),
    .wr_dat (up_data[2*width-1:width]),
    .rd_rdy (a_ready),
    .rd_vld (a_valid),
    .rd_dat (a_data),
    .full   (full_a)
  );

  split_pair_fifo2 #(.W(width)) u_buf_b (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (up_xfer),
    .wr_dat (up_data[width-1:0]),
    .rd_rdy (b_ready),
    .rd_vld (b_valid),
    .rd_dat (b_data),
    .full   (full_b)
  );

endmodule

// File: tb/tb_split_pair_using_double_buffers.sv
module tb_split_pair_using_double_buffers;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [15:0] up_data;
  logic        a_valid, a_ready;
  logic [7:0]  a_data;
  logic        b_valid, b_ready;
  logic [7:0]  b_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rst = 0;
  bit rnd_on = 0;
  bit mon_on = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  split_pair_using_double_buffers #(.width(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Offer one word until accepted; on acceptance push the hand-computed halves.
  task automatic send(input logic [15:0] w, input logic [7:0] ea, input logic [7:0] eb);
    bit done = 0;
    up_valid = 1'b1;
    up_data  = w;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (up_ready) begin
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && exp_b.size() == 0) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare every output handshake against the scoreboard, and check stall stability.
  initial begin
    bit         pa_stall = 0, pb_stall = 0;
    logic [7:0] pa_dat = '0, pb_dat = '0;
    int         p_rst = 0;
    forever begin
      @(negedge clk);
      if (mon_on && rst) begin
        if (p_rst == n_rst) begin
          if (pa_stall) begin
            chk("a_stall_valid", {31'd0, a_valid}, 32'd1);
            chk("a_stall_data", {24'd0, a_data}, {24'd0, pa_dat});
          end
          if (pb_stall) begin
            chk("b_stall_valid", {31'd0, b_valid}, 32'd1);
            chk("b_stall_data", {24'd0, b_data}, {24'd0, pb_dat});
          end
        end
        if (a_valid && a_ready) begin
          if (exp_a.size() == 0) chk("a_unexpected", {24'd0, a_data}, 32'hFFFF_FFFF);
          else chk("a_data", {24'd0, a_data}, {24'd0, exp_a.pop_front()});
        end
        if (b_valid && b_ready) begin
          if (exp_b.size() == 0) chk("b_unexpected", {24'd0, b_data}, 32'hFFFF_FFFF);
          else chk("b_data", {24'd0, b_data}, {24'd0, exp_b.pop_front()});
        end
        pa_stall = a_valid && !a_ready;
        pb_stall = b_valid && !b_ready;
        pa_dat   = a_data;
        pb_dat   = b_data;
        p_rst    = n_rst;
      end
    end
  end

  initial begin
    rst      = 1'b0;
    up_valid = 1'b1;
    up_data  = 16'hDEAD;
    a_ready  = 1'b1;
    b_ready  = 1'b1;

    // Reset held for 3 cycles with up_valid high: nothing valid, up_ready high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    up_valid = 1'b0;
    mon_on   = 1'b1;
    @(negedge clk);
    chk("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("post_rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("post_rst_up_ready", {31'd0, up_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Streaming: two back-to-back words, outputs on consecutive cycles.
    up_valid = 1'b1;
    up_data  = 16'h1234;
    @(negedge clk);
    chk("stream_rdy0", {31'd0, up_ready}, 32'd1);
    exp_a.push_back(8'h12);
    exp_b.push_back(8'h34);
    @(posedge clk);
    #1;
    up_data = 16'h5678;
    @(negedge clk);
    chk("stream_a0_valid", {31'd0, a_valid}, 32'd1);
    chk("stream_a0", {24'd0, a_data}, 32'h12);
    chk("stream_b0", {24'd0, b_data}, 32'h34);
    chk("stream_rdy1", {31'd0, up_ready}, 32'd1);
    exp_a.push_back(8'h56);
    exp_b.push_back(8'h78);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    @(negedge clk);
    chk("stream_a1", {24'd0, a_data}, 32'h56);
    chk("stream_b1", {24'd0, b_data}, 32'h78);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stream_idle_a", {31'd0, a_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure on a: third word waits until a drains.
    a_ready = 1'b0;
    b_ready = 1'b1;
    send(16'h0102, 8'h01, 8'h02);
    send(16'h0304, 8'h03, 8'h04);
    up_valid = 1'b1;
    up_data  = 16'h0506;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_up_ready_low", {31'd0, up_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    a_ready = 1'b1;
    send(16'h0506, 8'h05, 8'h06);
    drain();

    // Count-1 concurrency: one word buffered, push and pop both channels together.
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(16'h1122, 8'h11, 8'h22);
    a_ready = 1'b1;
    b_ready = 1'b1;
    send(16'hAABB, 8'hAA, 8'hBB);
    a_ready = 1'b0;
    b_ready = 1'b0;
    @(negedge clk);
    chk("c1_a_valid", {31'd0, a_valid}, 32'd1);
    chk("c1_a_head", {24'd0, a_data}, 32'hAA);
    chk("c1_b_head", {24'd0, b_data}, 32'hBB);
    chk("c1_up_ready", {31'd0, up_ready}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Mid-operation reset with both buffers full.
    a_ready = 1'b0;
    b_ready = 1'b0;
    send(16'h1111, 8'h11, 8'h11);
    send(16'h2222, 8'h22, 8'h22);
    @(negedge clk);
    chk("full_up_ready", {31'd0, up_ready}, 32'd0);
    #2;
    rst = 1'b0;
    n_rst++;
    exp_a.delete();
    exp_b.delete();
    #1;
    chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("mid_rst_up_ready", {31'd0, up_ready}, 32'd1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    send(16'h0F0E, 8'h0F, 8'h0E);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_idle", {31'd0, a_valid | b_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Random stress: random valid and readies, scoreboard from the word halves.
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 2000; n++) begin
          logic [15:0] w;
          bit          done;
          w    = 16'($urandom);
          done = 0;
          for (int c = 0; c < 200 && !done; c++) begin
            up_valid = 1'($urandom_range(0, 1));
            up_data  = w;
            @(negedge clk);
            if (up_valid && up_ready) begin
              exp_a.push_back(w[15:8]);
              exp_b.push_back(w[7:0]);
              done = 1;
            end
            @(posedge clk);
            #1;
          end
          if (!done) chk("rand_timeout", 32'd0, 32'd1);
        end
        up_valid = 1'b0;
        rnd_on   = 1'b0;
      end
      begin
        while (rnd_on) begin
          a_ready = 1'($urandom_range(0, 1));
          b_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("final_exp_a_empty", exp_a.size(), 32'd0);
    chk("final_exp_b_empty", exp_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
